// File: rtl/stack_pkg.sv
// Shared definitions for the stack controller: command encodings, FSM states and
// default data/address widths.
package stack_pkg;

    localparam int WIDTH_DEF  = 16;
    localparam int AWIDTH_DEF = 16;

    typedef enum logic [1:0] {
        CMD_PUSH     = 2'b00,
        CMD_POP      = 2'b01,
        CMD_REPLACE2 = 2'b10,
        CMD_PEEK     = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_READ = 2'b10,
        ST_RESP = 2'b11
    } state_e;

endpackage

// File: rtl/stack_ptr.sv
// Stack depth register plus the write/read address arithmetic. Depth counts
// 0..DEPTH and wraps; slot pointers are taken modulo DEPTH.
module stack_ptr
    import stack_pkg::*;
#(
    parameter int                 AWIDTH = AWIDTH_DEF,
    parameter int                 DEPTH  = 64,
    parameter logic [AWIDTH-1:0]  BASE   = AWIDTH'(1),
    localparam int                DW     = $clog2(DEPTH + 1),
    localparam int                PW     = $clog2(DEPTH)
) (
    input  logic              c_CLOCK,
    input  logic              c_RESET,
    input  logic              i_update,
    input  cmd_e              i_cmd,
    output logic [DW-1:0]     o_depth,
    output logic [AWIDTH-1:0] o_waddr,
    output logic [AWIDTH-1:0] o_raddr_next
);

    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

    logic [DW-1:0] depth_q, depth_d;
    logic [DW-1:0] depth_inc, depth_dec, depth_after;
    logic [PW-1:0] wr_ptr, rd_ptr;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        depth_inc   = (depth_q == DEPTH_MAX) ? '0 : depth_q + DW'(1);
        depth_dec   = (depth_q == '0) ? DEPTH_MAX : depth_q - DW'(1);
        depth_after = depth_q;
        wr_ptr      = depth_q[PW-1:0];
        case (i_cmd)
            CMD_PUSH:     depth_after = depth_inc;
            CMD_POP:      depth_after = depth_dec;
            CMD_REPLACE2: begin
                depth_after = depth_dec;
                wr_ptr      = depth_q[PW-1:0] - PW'(2);
            end
            default:      depth_after = depth_q;
        endcase
        // Slot of the new top: the low bits of depth-1 give the modulo-DEPTH wrap.
        rd_ptr  = depth_after[PW-1:0] - PW'(1);
        depth_d = i_update ? depth_after : depth_q;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge c_CLOCK or posedge c_RESET) begin
        if (c_RESET) depth_q <= '0;
        else         depth_q <= depth_d;
    end

    assign o_depth      = depth_q;
    assign o_waddr      = BASE + AWIDTH'(wr_ptr);
    assign o_raddr_next = BASE + AWIDTH'(rd_ptr);

endmodule

// File: rtl/stack_ctrl.sv
// Data-stack controller: turns push/pop/replace/peek into write and dual-read memory
// cycles and returns TOS/NOS. Define STACK_CHECK_EN to reject overflow/underflow.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int                 WIDTH  = WIDTH_DEF,
    parameter int                 AWIDTH = AWIDTH_DEF,
    parameter int                 DEPTH  = 64,
    parameter logic [AWIDTH-1:0]  BASE   = AWIDTH'(1),
    localparam int                DW     = $clog2(DEPTH + 1)
) (
    input  logic              c_CLOCK,
    input  logic              c_RESET,
    input  logic              i_VALID,
    input  logic [1:0]        i_CMD,
    input  logic [WIDTH-1:0]  i_DATA,
    output logic              o_READY,
    output logic [WIDTH-1:0]  o_TOS,
    output logic [WIDTH-1:0]  o_NOS,
    output logic              o_RVALID,
    output logic [DW-1:0]     o_DEPTH,
    output logic              o_ERR,
    output logic [AWIDTH-1:0] o_RADDR,
    output logic [AWIDTH-1:0] o_WADDR,
    output logic [WIDTH-1:0]  o_WDATA,
    output logic              o_WRITE,
    input  logic [WIDTH-1:0]  i_OP1,
    input  logic [WIDTH-1:0]  i_OP2
);

    state_e             state_q, state_d;
    cmd_e               cmd_q, cmd_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               err_q, err_d;
    logic [AWIDTH-1:0]  raddr_q, raddr_d;
    logic [WIDTH-1:0]   tos_q, tos_d;
    logic [WIDTH-1:0]   nos_q, nos_d;
    logic               rvalid_q, rvalid_d;

    logic               accept;
    logic               reject;
    logic               ptr_update;
    logic [DW-1:0]      depth;
    logic [AWIDTH-1:0]  raddr_next;

    assign accept     = i_VALID && (state_q == ST_IDLE);
    assign ptr_update = (state_q == ST_EXEC) && !err_q;

    stack_ptr #(
        .AWIDTH (AWIDTH),
        .DEPTH  (DEPTH),
        .BASE   (BASE)
    ) u_ptr (
        .c_CLOCK      (c_CLOCK),
        .c_RESET      (c_RESET),
        .i_update     (ptr_update),
        .i_cmd        (cmd_q),
        .o_depth      (depth),
        .o_waddr      (o_WADDR),
        .o_raddr_next (raddr_next)
    );

`ifdef STACK_CHECK_EN
    always_comb begin
        reject = 1'b0;
        case (cmd_e'(i_CMD))
            CMD_PUSH:     reject = (depth == DW'(DEPTH));
            CMD_POP:      reject = (depth == '0);
            CMD_REPLACE2: reject = (depth < DW'(2));
            default:      reject = 1'b0;
        endcase
    end
`else
    assign reject = 1'b0;
`endif

    always_ff @(posedge c_CLOCK or posedge c_RESET) begin
        if (c_RESET) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = err_q ? ST_IDLE : ST_READ;
            ST_READ: state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The write strobe is decoded from the state so an asynchronous reset kills it at once.
    always_comb begin
        o_READY = (state_q == ST_IDLE);
        o_ERR   = (state_q == ST_EXEC) && err_q;
        o_WRITE = (state_q == ST_EXEC) && !err_q &&
                  ((cmd_q == CMD_PUSH) || (cmd_q == CMD_REPLACE2));
    end

    always_comb begin
        cmd_d    = cmd_q;
        data_d   = data_q;
        err_d    = err_q;
        raddr_d  = raddr_q;
        tos_d    = tos_q;
        nos_d    = nos_q;
        rvalid_d = (state_q == ST_RESP);
        if (accept) begin
            cmd_d  = cmd_e'(i_CMD);
            data_d = i_DATA;
            err_d  = reject;
        end
        if (ptr_update) raddr_d = raddr_next;
        if (state_q == ST_RESP) begin
            tos_d = i_OP1;
            nos_d = i_OP2;
        end
    end

    always_ff @(posedge c_CLOCK or posedge c_RESET) begin
        if (c_RESET) begin
            cmd_q    <= CMD_PUSH;
            data_q   <= '0;
            err_q    <= 1'b0;
            raddr_q  <= '0;
            tos_q    <= '0;
            nos_q    <= '0;
            rvalid_q <= 1'b0;
        end else begin
            cmd_q    <= cmd_d;
            data_q   <= data_d;
            err_q    <= err_d;
            raddr_q  <= raddr_d;
            tos_q    <= tos_d;
            nos_q    <= nos_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign o_TOS    = tos_q;
    assign o_NOS    = nos_q;
    assign o_RVALID = rvalid_q;
    assign o_DEPTH  = depth;
    assign o_RADDR  = raddr_q;
    assign o_WDATA  = data_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a dual-read memory model; covers the wrap
// behaviour by default and the rejection paths when STACK_CHECK_EN is defined.
module tb_stack_ctrl;

    localparam logic [1:0] C_PUSH = 2'b00;
    localparam logic [1:0] C_POP  = 2'b01;
    localparam logic [1:0] C_REPL = 2'b10;
    localparam logic [1:0] C_PEEK = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [1:0]  i_cmd = 2'b00;
    logic [15:0] i_data = 16'h0;
    logic        o_ready, o_rvalid, o_err, o_write;
    logic [15:0] o_tos, o_nos, o_raddr, o_waddr, o_wdata;
    logic [6:0]  o_depth;
    logic [15:0] op1 = 16'h0;
    logic [15:0] op2 = 16'h0;
    logic [15:0] raddr_m1;

    logic [15:0] mem [0:65535];

    int errors = 0;
    int checks = 0;
    int wr_count = 0;
    int err_count = 0;
    logic [15:0] last_waddr = 16'h0;
    logic [15:0] last_wdata = 16'h0;

    stack_ctrl dut (
        .c_CLOCK  (clk),
        .c_RESET  (rst),
        .i_VALID  (i_valid),
        .i_CMD    (i_cmd),
        .i_DATA   (i_data),
        .o_READY  (o_ready),
        .o_TOS    (o_tos),
        .o_NOS    (o_nos),
        .o_RVALID (o_rvalid),
        .o_DEPTH  (o_depth),
        .o_ERR    (o_err),
        .o_RADDR  (o_raddr),
        .o_WADDR  (o_waddr),
        .o_WDATA  (o_wdata),
        .o_WRITE  (o_write),
        .i_OP1    (op1),
        .i_OP2    (op2)
    );

    always #5 clk = ~clk;

    assign raddr_m1 = o_raddr - 16'd1;

    // Memory: write on the edge, registered dual read one cycle after the address.
    always @(posedge clk) begin
        if (o_write) mem[o_waddr] <= o_wdata;
        op1 <= mem[o_raddr];
        op2 <= mem[raddr_m1];
    end

    always @(negedge clk) begin
        if (o_write) begin
            wr_count++;
            last_waddr = o_waddr;
            last_wdata = o_wdata;
        end
        if (o_err) err_count++;
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        i_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue one command and wait (bounded) for the RVALID or ERR response.
    task automatic do_cmd(input logic [1:0] c, input logic [15:0] d,
                          output int lat, output logic saw_err);
        @(negedge clk);
        i_valid = 1'b1;
        i_cmd   = c;
        i_data  = d;
        @(posedge clk);
        #1 i_valid = 1'b0;
        lat = 0;
        saw_err = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (o_err) begin
                saw_err = 1'b1;
                lat = i;
                break;
            end
            if (o_rvalid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        checks++; if (o_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", o_rvalid); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", o_err); end
        checks++; if (o_write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b want 0", o_write); end
        checks++; if (o_depth !== 7'd0) begin errors++; $display("FAIL reset_depth: got %0d want 0", o_depth); end
        checks++; if (o_tos !== 16'h0) begin errors++; $display("FAIL reset_tos: got %h want 0000", o_tos); end
        checks++; if (o_nos !== 16'h0) begin errors++; $display("FAIL reset_nos: got %h want 0000", o_nos); end
    endtask

    task automatic test_push();
        int lat;
        logic e;
        int wc0;
        wc0 = wr_count;
        do_cmd(C_PUSH, 16'hA5A5, lat, e);
        checks++; if (lat !== 4 || e !== 1'b0) begin errors++; $display("FAIL push_latency: got lat=%0d err=%b want lat=4 err=0", lat, e); end
        checks++; if (wr_count !== wc0 + 1) begin errors++; $display("FAIL push_write_count: got %0d want %0d", wr_count, wc0 + 1); end
        checks++; if (last_waddr !== 16'h0001) begin errors++; $display("FAIL push_waddr: got %h want 0001", last_waddr); end
        checks++; if (last_wdata !== 16'hA5A5) begin errors++; $display("FAIL push_wdata: got %h want a5a5", last_wdata); end
        checks++; if (o_tos !== 16'hA5A5) begin errors++; $display("FAIL push_tos: got %h want a5a5", o_tos); end
        checks++; if (o_depth !== 7'd1) begin errors++; $display("FAIL push_depth: got %0d want 1", o_depth); end
        checks++; if (o_raddr !== 16'h0001) begin errors++; $display("FAIL push_raddr: got %h want 0001", o_raddr); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL push_ready: got %b want 1", o_ready); end
    endtask

    task automatic test_replace2();
        int lat;
        logic e;
        apply_reset();
        do_cmd(C_PUSH, 16'h0003, lat, e);
        do_cmd(C_PUSH, 16'h0004, lat, e);
        checks++; if (o_tos !== 16'h0004 || o_nos !== 16'h0003) begin errors++; $display("FAIL two_push_tos_nos: got %h/%h want 0004/0003", o_tos, o_nos); end
        checks++; if (last_waddr !== 16'h0002) begin errors++; $display("FAIL second_push_waddr: got %h want 0002", last_waddr); end
        do_cmd(C_REPL, 16'h0007, lat, e);
        checks++; if (lat !== 4 || e !== 1'b0) begin errors++; $display("FAIL repl_latency: got lat=%0d err=%b want lat=4 err=0", lat, e); end
        checks++; if (last_waddr !== 16'h0001 || last_wdata !== 16'h0007) begin errors++; $display("FAIL repl_write: got %h@%h want 0007@0001", last_wdata, last_waddr); end
        checks++; if (o_tos !== 16'h0007) begin errors++; $display("FAIL repl_tos: got %h want 0007", o_tos); end
        checks++; if (o_depth !== 7'd1) begin errors++; $display("FAIL repl_depth: got %0d want 1", o_depth); end
    endtask

    task automatic test_pop();
        int lat;
        logic e;
        int wc0;
        apply_reset();
        do_cmd(C_PUSH, 16'h0001, lat, e);
        do_cmd(C_PUSH, 16'h0002, lat, e);
        wc0 = wr_count;
        do_cmd(C_POP, 16'hFFFF, lat, e);
        checks++; if (lat !== 4 || e !== 1'b0) begin errors++; $display("FAIL pop_latency: got lat=%0d err=%b want lat=4 err=0", lat, e); end
        checks++; if (wr_count !== wc0) begin errors++; $display("FAIL pop_no_write: got %0d writes want %0d", wr_count, wc0); end
        checks++; if (o_tos !== 16'h0001) begin errors++; $display("FAIL pop_tos: got %h want 0001", o_tos); end
        checks++; if (o_depth !== 7'd1) begin errors++; $display("FAIL pop_depth: got %0d want 1", o_depth); end
    endtask

    task automatic test_back_to_back();
        int acc;
        int rv;
        int wc0;
        acc = 0;
        rv = 0;
        wc0 = wr_count;
        @(negedge clk);
        i_valid = 1'b1;
        i_cmd   = C_PEEK;
        i_data  = 16'h0;
        for (int i = 0; i < 8; i++) begin
            if (o_ready) acc++;
            if (o_rvalid) rv++;
            @(negedge clk);
        end
        i_valid = 1'b0;
        for (int j = 0; j < 6; j++) begin
            if (o_rvalid) rv++;
            @(negedge clk);
        end
        checks++; if (acc !== 2) begin errors++; $display("FAIL b2b_accepts: got %0d want 2", acc); end
        checks++; if (rv !== 2) begin errors++; $display("FAIL b2b_rvalids: got %0d want 2", rv); end
        checks++; if (o_tos !== 16'h0001 || o_depth !== 7'd1) begin errors++; $display("FAIL peek_state: got tos=%h depth=%0d want tos=0001 depth=1", o_tos, o_depth); end
        checks++; if (wr_count !== wc0) begin errors++; $display("FAIL peek_no_write: got %0d writes want %0d", wr_count, wc0); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        i_valid = 1'b1;
        i_cmd   = C_PUSH;
        i_data  = 16'h1234;
        @(posedge clk);
        #1 i_valid = 1'b0;
        @(negedge clk);
        checks++; if (o_write !== 1'b1) begin errors++; $display("FAIL mid_exec_write: got %b want 1", o_write); end
        #2 rst = 1'b1;
        #1;
        checks++; if (o_write !== 1'b0) begin errors++; $display("FAIL mid_reset_write: got %b want 0", o_write); end
        checks++; if (o_depth !== 7'd0) begin errors++; $display("FAIL mid_reset_depth: got %0d want 0", o_depth); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b want 1", o_ready); end
        checks++; if (mem[1] !== 16'h0001) begin errors++; $display("FAIL mid_reset_dropped_write: got mem[1]=%h want 0001", mem[1]); end
    endtask

`ifdef STACK_CHECK_EN
    task automatic test_check();
        int lat;
        logic e;
        int rv;
        int wc0;
        apply_reset();
        do_cmd(C_POP, 16'h0, lat, e);
        checks++; if (e !== 1'b1 || lat !== 1) begin errors++; $display("FAIL underflow_err: got err=%b lat=%0d want err=1 lat=1", e, lat); end
        rv = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (o_rvalid) rv++;
        end
        checks++; if (rv !== 0) begin errors++; $display("FAIL underflow_no_rvalid: got %0d pulses want 0", rv); end
        checks++; if (o_depth !== 7'd0) begin errors++; $display("FAIL underflow_depth: got %0d want 0", o_depth); end
        for (int i = 0; i < 64; i++) do_cmd(C_PUSH, 16'(i), lat, e);
        checks++; if (o_depth !== 7'd64) begin errors++; $display("FAIL full_depth: got %0d want 64", o_depth); end
        checks++; if (o_tos !== 16'd63 || o_nos !== 16'd62) begin errors++; $display("FAIL full_tos_nos: got %h/%h want 003f/003e", o_tos, o_nos); end
        wc0 = wr_count;
        do_cmd(C_PUSH, 16'hDEAD, lat, e);
        checks++; if (e !== 1'b1 || lat !== 1) begin errors++; $display("FAIL overflow_err: got err=%b lat=%0d want err=1 lat=1", e, lat); end
        checks++; if (o_depth !== 7'd64 || wr_count !== wc0) begin errors++; $display("FAIL overflow_state: got depth=%0d writes=%0d want 64/%0d", o_depth, wr_count, wc0); end
        apply_reset();
        do_cmd(C_PUSH, 16'h0055, lat, e);
        do_cmd(C_REPL, 16'h0066, lat, e);
        checks++; if (e !== 1'b1 || o_depth !== 7'd1) begin errors++; $display("FAIL repl_short_err: got err=%b depth=%0d want err=1 depth=1", e, o_depth); end
    endtask
`else
    task automatic test_wrap();
        int lat;
        logic e;
        apply_reset();
        do_cmd(C_POP, 16'h0, lat, e);
        checks++; if (e !== 1'b0 || lat !== 4) begin errors++; $display("FAIL wrap_pop_resp: got err=%b lat=%0d want err=0 lat=4", e, lat); end
        checks++; if (o_depth !== 7'd64) begin errors++; $display("FAIL wrap_pop_depth: got %0d want 64", o_depth); end
        checks++; if (o_raddr !== 16'h0040) begin errors++; $display("FAIL wrap_pop_raddr: got %h want 0040", o_raddr); end
        do_cmd(C_PUSH, 16'hBEEF, lat, e);
        checks++; if (last_waddr !== 16'h0001 || o_depth !== 7'd0) begin errors++; $display("FAIL wrap_push: got waddr=%h depth=%0d want 0001/0", last_waddr, o_depth); end
        checks++; if (err_count !== 0) begin errors++; $display("FAIL err_tied_low: got %0d pulses want 0", err_count); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
        test_reset();
        test_push();
        test_replace2();
        test_pop();
        test_back_to_back();
        test_reset_mid();
`ifdef STACK_CHECK_EN
        test_check();
`else
        test_wrap();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
